// File: rtl/fu_op_decoder_issuer.sv
// Opcode decoder/issuer: FIFO-buffered commands, one-hot instruction, valid/ready output stage.
// Optional macro DEC_SEL_CHECK_EN drops commands with illegal operand selects and pulses sel_err.
module fu_op_decoder_issuer #(
  parameter int DEPTH = 4,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [2:0]      in_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      instruction,
  output logic [2:0]      select,
  output logic [CNTW-1:0] count,
  output logic            sel_err
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state;
  logic [5:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    head_op;
  logic [2:0]    head_sel;
  logic          head_ok;
  logic          push;
  logic          pop;
  logic          load;

  assign in_ready  = (count < CNTW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign head_op   = mem[rd_ptr][5:3];
  assign head_sel  = mem[rd_ptr][2:0];

  // The head may leave the FIFO whenever the output register is empty or being consumed.
  assign pop  = (count != '0) && (!out_valid || out_ready);
  assign load = pop && head_ok;

`ifdef DEC_SEL_CHECK_EN
  assign head_ok = (head_sel == 3'b011) || (head_sel == 3'b101) || (head_sel == 3'b110);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= pop && !head_ok;
    end
  end
`else
  assign head_ok = 1'b1;
  assign sel_err = 1'b0;
`endif

  // Storage carries no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_op, in_sel};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage: instruction/select only change on a load, so they hold while stalled or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instruction <= 8'h00;
      select      <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state       <= HOLD;
            instruction <= 8'(1) << head_op;
            select      <= head_sel;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (load) begin
              instruction <= 8'(1) << head_op;
              select      <= head_sel;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fu_op_decoder_issuer.sv
// Directed, table-driven bench for fu_op_decoder_issuer (DEPTH=4).
module tb_fu_op_decoder_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [2:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] instruction;
  logic [2:0] select;
  logic [2:0] count;
  logic       sel_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] op;
    logic [2:0] sel;
    logic [7:0] exp_instr;
  } vec_t;

  vec_t tbl [8];

  fu_op_decoder_issuer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .select(select),
    .count(count), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] penc(input logic [7:0] w);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (w[i]) r = 3'(i);
    return r;
  endfunction

  logic [7:0] iss_instr [$];
  logic [2:0] iss_sel   [$];
  int         pulses;
  int         accepted;
  logic [7:0] held_instr;
  logic [2:0] held_sel;

  initial begin
    tbl[0] = '{3'd0, 3'b011, 8'h01};
    tbl[1] = '{3'd1, 3'b101, 8'h02};
    tbl[2] = '{3'd2, 3'b110, 8'h04};
    tbl[3] = '{3'd3, 3'b011, 8'h08};
    tbl[4] = '{3'd4, 3'b101, 8'h10};
    tbl[5] = '{3'd5, 3'b110, 8'h20};
    tbl[6] = '{3'd6, 3'b011, 8'h40};
    tbl[7] = '{3'd7, 3'b101, 8'h80};

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_sel = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_instruction", instruction, 8'h00);
    check("rst_select", select, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sel_err", sel_err, 0);

    // single command latency
    in_valid = 1'b1; in_op = 3'b101; in_sel = 3'b110;
    tick();
    in_valid = 1'b0;
    check("lat_not_yet", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_instr", instruction, 8'h20);
    check("lat_sel", select, 3'b110);
    check("lat_penc", penc(instruction), 3'b101);
    tick();
    check("lat_drained", out_valid, 0);

    // back-to-back stream of all opcodes
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      if (i < 8) begin in_op = tbl[i].op; in_sel = tbl[i].sel; end
      tick();
      if (i >= 1 && i <= 8) begin
        check($sformatf("stream_valid_%0d", i - 1), out_valid, 1);
        check($sformatf("stream_instr_%0d", i - 1), instruction, tbl[i - 1].exp_instr);
        check($sformatf("stream_sel_%0d", i - 1), select, tbl[i - 1].sel);
        check($sformatf("stream_penc_%0d", i - 1), penc(instruction), tbl[i - 1].op);
        check($sformatf("stream_count_%0d", i - 1), (count <= 3'd1), 1);
      end
    end
    in_valid = 1'b0;
    check("stream_end_idle", out_valid, 0);

    // backpressure: fill output + FIFO, then drain in order
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_op = tbl[i].op; in_sel = tbl[i].sel;
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", accepted, 5);
    check("bp_in_ready", in_ready, 0);
    check("bp_count", count, 4);
    check("bp_head_instr", instruction, tbl[1].exp_instr);
    held_instr = instruction;
    held_sel   = select;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_stable_instr_%0d", i), instruction, held_instr);
      check($sformatf("bp_stable_sel_%0d", i), select, held_sel);
      check($sformatf("bp_stable_valid_%0d", i), out_valid, 1);
    end
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("drain_valid_%0d", k), out_valid, 1);
      check($sformatf("drain_instr_%0d", k), instruction, tbl[k].exp_instr);
      check($sformatf("drain_sel_%0d", k), select, tbl[k].sel);
      check($sformatf("drain_in_ready_%0d", k), in_ready, 1);
    end
    tick();
    check("drain_idle", out_valid, 0);
    check("drain_count", count, 0);

    // illegal select among legal neighbours
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 3);
      case (i)
        0: begin in_op = 3'd2; in_sel = 3'b011; end
        1: begin in_op = 3'd3; in_sel = 3'b111; end
        2: begin in_op = 3'd4; in_sel = 3'b101; end
        default: ;
      endcase
      tick();
      if (out_valid) begin
        iss_instr.push_back(instruction);
        iss_sel.push_back(select);
      end
      if (sel_err) pulses++;
    end
    in_valid = 1'b0;
`ifdef DEC_SEL_CHECK_EN
    check("sel_issued", iss_instr.size(), 2);
    check("sel_err_pulses", pulses, 1);
    if (iss_instr.size() == 2) begin
      check("sel_first_instr", iss_instr[0], 8'h04);
      check("sel_first_sel", iss_sel[0], 3'b011);
      check("sel_second_instr", iss_instr[1], 8'h10);
      check("sel_second_sel", iss_sel[1], 3'b101);
    end
`else
    check("sel_issued", iss_instr.size(), 3);
    check("sel_err_pulses", pulses, 0);
    if (iss_instr.size() == 3) begin
      check("sel_first_instr", iss_instr[0], 8'h04);
      check("sel_mid_instr", iss_instr[1], 8'h08);
      check("sel_mid_sel", iss_sel[1], 3'b111);
      check("sel_last_instr", iss_instr[2], 8'h10);
      check("sel_last_sel", iss_sel[2], 3'b101);
    end
`endif

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = tbl[i].op; in_sel = tbl[i].sel;
      tick();
    end
    in_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_count", count, 3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_instr", instruction, 8'h00);
    check("mid_rst_select", select, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_idle", out_valid, 0);
    in_valid = 1'b1; in_op = 3'd7; in_sel = 3'b101;
    tick();
    in_valid = 1'b0;
    tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_instr", instruction, 8'h80);
    check("post_rst_sel", select, 3'b101);
    tick();
    check("post_rst_drained", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
